// File: rtl/jtl_chain_timing_model.sv
// Cycle-based timing model of a multi-channel chain of bias-dependent JTL stages.
// Toggle-encoded pulses are delayed by STAGES x d ticks; edges inside the critical window are flagged.
module jtl_chain_timing_model #(
    parameter int CH       = 4,
    parameter int STAGES   = 2,
    parameter int DEPTH    = 4,
    parameter int TS_W     = 12,
    parameter int BIAS_W   = 8,
    parameter int B_NOM    = 128,
    parameter int D_NOM    = 60,
    parameter int D_SLOPE  = 16,
    parameter int D_MAX    = 255,
    parameter int CT_NOM   = 92,
    parameter int CT_SLOPE = 8,
    parameter int B_MIN    = 60,
    parameter int B_MAX    = 200,
    parameter int SETTLE   = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIAS_W-1:0] bias_code_i,
    input  logic [CH-1:0]     in_i,
    output logic [CH-1:0]     out_o,
    output logic [CH-1:0]     err_o,
    output logic              ovf_o,
    output logic [15:0]       viol_cnt_o,
    output logic              bias_fault_o,
    output logic [CH-1:0]     dbg_guard_o
);
    // DEPTH is a power of two >= 2 so the slot pointers wrap on their own.
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int SET_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int CT_CAP = (1 << TS_W) - 1;
    localparam logic [SET_W-1:0] SETTLE_V = SET_W'(SETTLE);

    typedef enum logic {ST_IDLE = 1'b0, ST_GUARD = 1'b1} state_e;

    logic [BIAS_W-1:0] bias_q;
    logic [CH-1:0]     prev_q;
    logic [CH-1:0]     out_q;
    logic [CH-1:0]     err_q;
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   t_q;
    logic [TS_W-1:0]   ct_q;
    logic [SET_W-1:0]  settle_q;
    logic              cfg_vld_q;
    logic              bias_fault_q;
    logic              ovf_q;
    logic [15:0]       viol_cnt_q;

    state_e            state_q   [CH];
    logic [TS_W-1:0]   guard_q   [CH];
    logic [TS_W-1:0]   slot_ts_q [CH][DEPTH];
    logic [DEPTH-1:0]  slot_vld_q[CH];
    logic [PTR_W-1:0]  head_q    [CH];
    logic [PTR_W-1:0]  tail_q    [CH];

    logic signed [31:0] bias_diff;
    logic signed [31:0] d_raw;
    logic signed [31:0] ct_raw;
    logic signed [31:0] d_cl;
    logic signed [31:0] ct_cl;
    logic [TS_W-1:0]    t_d;
    logic [TS_W-1:0]    ct_d;
    logic               bias_fault_d;

    logic               live;
    logic [CH-1:0]      edge_v;
    logic [CH-1:0]      accept;
    logic [CH-1:0]      viol;
    logic [CH-1:0]      pop;
    logic [CH-1:0]      push;
    logic [CH-1:0]      drop;
    logic [16:0]        viol_sum;
    logic [15:0]        viol_cnt_d;

    // Bias-dependent constants; the slope terms are in 1/64 tick, floored by the arithmetic shift.
    always_comb begin
        bias_diff = $signed(32'(bias_q)) - B_NOM;
        d_raw     = D_NOM  - ((bias_diff * D_SLOPE)  >>> 6);
        ct_raw    = CT_NOM - ((bias_diff * CT_SLOPE) >>> 6);

        if (d_raw < 1)          d_cl = 1;
        else if (d_raw > D_MAX) d_cl = D_MAX;
        else                    d_cl = d_raw;

        if (ct_raw < 1)           ct_cl = 1;
        else if (ct_raw > CT_CAP) ct_cl = CT_CAP;
        else                      ct_cl = ct_raw;

        t_d          = TS_W'(STAGES * d_cl);
        ct_d         = TS_W'(ct_cl);
        bias_fault_d = (32'(bias_q) < B_MIN) || (32'(bias_q) > B_MAX);
    end

    always_comb begin
        live     = cfg_vld_q && !bias_fault_q && (settle_q == SETTLE_V);
        edge_v   = '0;
        accept   = '0;
        viol     = '0;
        pop      = '0;
        push     = '0;
        drop     = '0;
        viol_sum = {1'b0, viol_cnt_q};
        for (int c = 0; c < CH; c++) begin
            edge_v[c] = live && (in_i[c] ^ prev_q[c]);
            // An edge on the cycle the guard has run down to zero is still in time.
            accept[c] = edge_v[c] && ((state_q[c] == ST_IDLE) || (guard_q[c] == '0));
            viol[c]   = edge_v[c] && !accept[c];
            pop[c]    = slot_vld_q[c][head_q[c]] &&
                        ((ts_q - slot_ts_q[c][head_q[c]]) == t_q);
            // When full, tail == head, so a same-cycle pop frees exactly the slot being written.
            push[c]   = accept[c] && (!slot_vld_q[c][tail_q[c]] || pop[c]);
            drop[c]   = accept[c] && !push[c];
            viol_sum  = viol_sum + 17'(viol[c]);
        end
        viol_cnt_d = viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_q       <= bias_code_i;
            prev_q       <= in_i;
            ts_q         <= '0;
            t_q          <= '0;
            ct_q         <= '0;
            settle_q     <= '0;
            cfg_vld_q    <= 1'b0;
            bias_fault_q <= 1'b0;
            out_q        <= '0;
            err_q        <= '0;
            ovf_q        <= 1'b0;
            viol_cnt_q   <= '0;
            for (int c = 0; c < CH; c++) begin
                state_q[c]    <= ST_IDLE;
                guard_q[c]    <= '0;
                slot_vld_q[c] <= '0;
                head_q[c]     <= '0;
                tail_q[c]     <= '0;
            end
        end else begin
            prev_q       <= in_i;
            ts_q         <= ts_q + 1'b1;
            if (settle_q != SETTLE_V) settle_q <= settle_q + 1'b1;
            cfg_vld_q    <= 1'b1;
            t_q          <= t_d;
            ct_q         <= ct_d;
            bias_fault_q <= bias_fault_d;
            err_q        <= err_q | viol | {CH{bias_fault_q}};
            ovf_q        <= ovf_q | (|drop);
            viol_cnt_q   <= viol_cnt_d;
            for (int c = 0; c < CH; c++) begin
                if (pop[c]) begin
                    slot_vld_q[c][head_q[c]] <= 1'b0;
                    head_q[c]                <= head_q[c] + 1'b1;
                    out_q[c]                 <= ~out_q[c];
                end
                if (push[c]) begin
                    slot_ts_q[c][tail_q[c]]  <= ts_q;
                    slot_vld_q[c][tail_q[c]] <= 1'b1;
                    tail_q[c]                <= tail_q[c] + 1'b1;
                end
                // Accepted and violating edges both (re)open the guard window.
                if (edge_v[c]) begin
                    state_q[c] <= ST_GUARD;
                    guard_q[c] <= ct_q;
                end else if (state_q[c] == ST_GUARD) begin
                    if (guard_q[c] == '0) state_q[c] <= ST_IDLE;
                    else                  guard_q[c] <= guard_q[c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        dbg_guard_o = '0;
        for (int c = 0; c < CH; c++) begin
            dbg_guard_o[c] = (state_q[c] == ST_GUARD);
        end
    end

    assign out_o        = out_q;
    assign err_o        = err_q;
    assign ovf_o        = ovf_q;
    assign viol_cnt_o   = viol_cnt_q;
    assign bias_fault_o = bias_fault_q;

endmodule

// File: tb/tb_jtl_chain_timing_model.sv
// Directed bench for jtl_chain_timing_model: toggle times are hand-computed from the bias code
// (bias 128: T=120, ct=92; bias 192: T=88, ct=84; bias 60: T=154, ct=101).
module tb_jtl_chain_timing_model;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    bias_r = 8'd128;
    logic [CH-1:0] in_r = '0;
    logic [CH-1:0] out_o;
    logic [CH-1:0] err_o;
    logic          ovf_o;
    logic [15:0]   viol_cnt_o;
    logic          bias_fault_o;
    logic [CH-1:0] dbg_guard_o;

    int            cyc = 0;
    int            base = 0;
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   obs_q[$];
    logic [CH-1:0] out_prev = '0;

    jtl_chain_timing_model dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bias_code_i  (bias_r),
        .in_i         (in_r),
        .out_o        (out_o),
        .err_o        (err_o),
        .ovf_o        (ovf_o),
        .viol_cnt_o   (viol_cnt_o),
        .bias_fault_o (bias_fault_o),
        .dbg_guard_o  (dbg_guard_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Log every output toggle as {channel, posedge number}.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < CH; c++) begin
                if (out_o[c] != out_prev[c]) obs_q.push_back({8'(c), 24'(cyc)});
            end
        end
        out_prev = out_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic do_reset(input logic [7:0] b);
        @(negedge clk);
        rst_n  = 1'b0;
        bias_r = b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Toggle the masked inputs so the edge is sampled at posedge number n.
    task automatic drive(input logic [CH-1:0] mask, input int n);
        run_to(n - 1);
        in_r = in_r ^ mask;
    endtask

    task automatic expect_tog(input int ch, input int n);
        exp_q.push_back({8'(ch), 24'(n)});
    endtask

    task automatic score(input string tag);
        logic [31:0] want;
        logic [31:0] got;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
            check(tag, got, want);
        end
        obs_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out"},  32'(out_o), 32'h0);
        check({tag, "_err"},  32'(err_o), 32'h0);
        check({tag, "_ovf"},  32'(ovf_o), 32'h0);
        check({tag, "_viol"}, 32'(viol_cnt_o), 32'h0);
        check({tag, "_bf"},   32'(bias_fault_o), 32'h0);
        check({tag, "_dbg"},  32'(dbg_guard_o), 32'h0);
    endtask

    initial begin
        // Nominal bias, single pulse: T = 120.
        do_reset(8'd128);
        check_idle("rst");
        drive(4'b0001, base + 100);
        run_to(base + 101);
        check("guard_open", 32'(dbg_guard_o), 32'h1);
        expect_tog(0, base + 220);
        run_to(base + 260);
        score("nominal");
        check("nominal_out", 32'(out_o), 32'h1);
        check("nominal_err", 32'(err_o), 32'h0);
        check("nominal_viol", 32'(viol_cnt_o), 32'h0);

        // Bias 192: d = 44, T = 88.
        do_reset(8'd192);
        drive(4'b0001, base + 100);
        drive(4'b0001, base + 300);
        expect_tog(0, base + 188);
        expect_tog(0, base + 388);
        run_to(base + 420);
        score("bias192");
        check("bias192_err", 32'(err_o), 32'h0);

        // Violations, guard reload, ct / ct+1 spacing, simultaneous violations.
        do_reset(8'd128);
        drive(4'b0010, base + 100);
        drive(4'b0010, base + 150);
        run_to(base + 150);
        check("viol_first", 32'(viol_cnt_o), 32'd1);
        check("viol_err1", 32'(err_o), 32'b0010);
        drive(4'b0010, base + 200);
        run_to(base + 200);
        check("viol_reload", 32'(viol_cnt_o), 32'd2);
        drive(4'b1100, base + 300);
        drive(4'b1000, base + 392);
        drive(4'b0100, base + 393);
        run_to(base + 393);
        check("viol_spacing", 32'(viol_cnt_o), 32'd3);
        drive(4'b0011, base + 600);
        drive(4'b0011, base + 610);
        check("viol_before_pair", 32'(viol_cnt_o), 32'd3);
        run_to(base + 610);
        check("viol_pair", 32'(viol_cnt_o), 32'd5);
        expect_tog(1, base + 220);
        expect_tog(2, base + 420);
        expect_tog(3, base + 420);
        expect_tog(2, base + 513);
        expect_tog(0, base + 720);
        expect_tog(1, base + 720);
        run_to(base + 760);
        score("viol");
        check("viol_err", 32'(err_o), 32'b1011);
        check("viol_ovf", 32'(ovf_o), 32'h0);

        // Settle window: edge at release+40 ignored, release+41 accepted.
        do_reset(8'd128);
        drive(4'b1111, base + 40);
        drive(4'b1111, base + 41);
        for (int c = 0; c < CH; c++) expect_tog(c, base + 161);
        run_to(base + 200);
        score("settle");
        check("settle_err", 32'(err_o), 32'h0);
        check("settle_viol", 32'(viol_cnt_o), 32'h0);

        // Lowest valid bias 60: T = 154, ct = 101 (floored slope term).
        do_reset(8'd60);
        drive(4'b0111, base + 100);
        drive(4'b0010, base + 201);
        drive(4'b0100, base + 202);
        expect_tog(0, base + 254);
        expect_tog(1, base + 254);
        expect_tog(2, base + 254);
        expect_tog(2, base + 356);
        run_to(base + 380);
        score("bias60");
        check("bias60_bf", 32'(bias_fault_o), 32'h0);
        check("bias60_viol", 32'(viol_cnt_o), 32'd1);
        check("bias60_err", 32'(err_o), 32'b0010);

        // Bias fault: all errors set, inputs ignored.
        do_reset(8'd30);
        run_to(base + 5);
        check("fault_bf", 32'(bias_fault_o), 32'h1);
        check("fault_err", 32'(err_o), 32'hF);
        drive(4'b1111, base + 50);
        drive(4'b1111, base + 100);
        drive(4'b0101, base + 150);
        run_to(base + 400);
        score("fault");
        check("fault_out", 32'(out_o), 32'h0);
        check("fault_viol", 32'(viol_cnt_o), 32'h0);
        do_reset(8'd201);
        run_to(base + 5);
        check("fault_hi_bf", 32'(bias_fault_o), 32'h1);

        // Timestamp wrap: edge at ts 4050 toggles at ts 74; then reset with a pulse pending.
        do_reset(8'd128);
        drive(4'b0001, base + 4051);
        expect_tog(0, base + 4171);
        run_to(base + 4180);
        score("wrap");
        drive(4'b0001, base + 4200);
        run_to(base + 4250);
        check("pending_out", 32'(out_o), 32'h1);
        do_reset(8'd128);
        check_idle("flush_rst");
        run_to(base + 400);
        score("flush");
        check("flush_out", 32'(out_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
